// File: rtl/tlc_pkg.sv
// rtl/tlc_pkg.sv - shared state encoding, phase index width and next-phase search for tlc_multi_phase
package tlc_pkg;

    localparam int PH_W = 2;

    typedef enum logic [1:0] {
        S_GREEN  = 2'b00,
        S_YELLOW = 2'b01,
        S_ALLRED = 2'b10
    } tlc_state_e;

    // First phase with demand, scanning cyclically from cur+1; cur itself is the last candidate.
    function automatic logic [PH_W-1:0] next_phase(input logic [3:0] dem,
                                                   input logic [PH_W-1:0] cur,
                                                   input int n);
        logic [PH_W-1:0] pick;
        logic            found;
        int              idx;
        pick  = cur;
        found = 1'b0;
        for (int k = 1; k <= n; k++) begin
            idx = (int'(cur) + k) % n;
            if (!found && dem[idx]) begin
                pick  = PH_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/tlc_multi_phase_if.sv
// rtl/tlc_multi_phase_if.sv - detector/lamp bundle for tlc_multi_phase; ped_req/walk only with TLC_PED_EN
interface tlc_multi_phase_if #(
    parameter int N_PHASES = 3
);
    import tlc_pkg::*;

    logic                ena;
    logic [N_PHASES-1:0] det;
    logic [N_PHASES-1:0] red;
    logic [N_PHASES-1:0] yel;
    logic [N_PHASES-1:0] grn;
    logic [PH_W-1:0]     active;
    logic [1:0]          st;
`ifdef TLC_PED_EN
    logic [N_PHASES-1:0] ped_req;
    logic [N_PHASES-1:0] walk;

    modport master (output ena, det, ped_req, input red, yel, grn, walk, active, st);
    modport slave  (input ena, det, ped_req, output red, yel, grn, walk, active, st);
`else
    modport master (output ena, det, input red, yel, grn, active, st);
    modport slave  (input ena, det, output red, yel, grn, active, st);
`endif

endinterface

// File: rtl/tlc_tick_gen.sv
// rtl/tlc_tick_gen.sv - prescaler producing a one-cycle tick every PRESCALE enabled cycles
module tlc_tick_gen #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic restart,
    output logic tick
);
    localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pc;

    assign tick = ena && (pc == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
        end else if (restart || tick) begin
            pc <= '0;
        end else if (ena) begin
            pc <= pc + 1'b1;
        end
    end

endmodule

// File: rtl/tlc_multi_phase.sv
// rtl/tlc_multi_phase.sv - multi-phase actuated traffic light controller
// Optional pedestrian walk feature enabled by TLC_PED_EN.
module tlc_multi_phase
    import tlc_pkg::*;
#(
    parameter int N_PHASES  = 3,
    parameter int PRESCALE  = 4,
    parameter int CNT_W     = 8,
    parameter int GREEN_MIN = 5,
    parameter int GREEN_MAX = 12,
    parameter int YEL_T     = 3,
    parameter int ALLRED_T  = 2,
    parameter int WALK_T    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    tlc_multi_phase_if.slave bus
);
    // The counter must keep running past GREEN_MAX when a walk interval is longer.
    localparam int               CSAT     = (GREEN_MAX > WALK_T) ? GREEN_MAX : WALK_T;
    localparam logic [CNT_W-1:0] CSAT_C   = CNT_W'(CSAT);
    localparam logic [CNT_W:0]   GMIN_C   = (CNT_W + 1)'(GREEN_MIN);
    localparam logic [CNT_W:0]   GMAX_C   = (CNT_W + 1)'(GREEN_MAX);
    localparam logic [CNT_W:0]   YEL_C    = (CNT_W + 1)'(YEL_T);
    localparam logic [CNT_W:0]   ALLRED_C = (CNT_W + 1)'(ALLRED_T);

    tlc_state_e          state;
    tlc_state_e          state_nx;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W:0]      cnt_p1;
    logic [PH_W-1:0]     act;
    logic [PH_W-1:0]     nxt_ph;
    logic [N_PHASES-1:0] req;
    logic [N_PHASES-1:0] dem;
    logic [N_PHASES-1:0] act_oh;
    logic [N_PHASES-1:0] clr;
    logic [N_PHASES-1:0] red_nx;
    logic [N_PHASES-1:0] yel_nx;
    logic [N_PHASES-1:0] grn_nx;
    logic                tick;
    logic                leave;
    logic                enter_grn;
    logic                dem_other;
    logic                gmin_ok;
    logic                gmax_ok;

    tlc_tick_gen #(
        .PRESCALE(PRESCALE)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (bus.ena),
        .restart(leave),
        .tick   (tick)
    );

    assign cnt_p1    = {1'b0, cnt} + 1'b1;
    assign act_oh    = {{(N_PHASES - 1){1'b0}}, 1'b1} << act;
    assign leave     = (state_nx != state);
    assign enter_grn = (state != S_GREEN) && (state_nx == S_GREEN);
    assign nxt_ph    = next_phase(4'(dem), act, N_PHASES);
    assign clr       = enter_grn ? ({{(N_PHASES - 1){1'b0}}, 1'b1} << nxt_ph) : '0;
    assign dem_other = |(dem & ~act_oh);
    assign gmax_ok   = (cnt_p1 >= GMAX_C);

`ifdef TLC_PED_EN
    localparam int WMIN = (WALK_T + 1 > GREEN_MIN) ? WALK_T + 1 : GREEN_MIN;

    logic [N_PHASES-1:0] ped;
    logic [N_PHASES-1:0] walk_nx;
    logic                ped_grn;

    assign dem     = req | ped;
    assign gmin_ok = cnt_p1 >= (ped_grn ? (CNT_W + 1)'(WMIN) : GMIN_C);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ped     <= '0;
            ped_grn <= 1'b0;
        end else begin
            ped <= (ped | bus.ped_req) & ~clr;
            if (enter_grn) begin
                ped_grn <= ped[nxt_ph];
            end
        end
    end

    always_comb begin
        walk_nx = '0;
        if (state == S_GREEN && ped_grn && cnt < CNT_W'(WALK_T)) begin
            walk_nx = act_oh;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.walk <= '0;
        end else begin
            bus.walk <= walk_nx;
        end
    end
`else
    assign dem     = req;
    assign gmin_ok = (cnt_p1 >= GMIN_C);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_ALLRED;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_GREEN: begin
                if (tick && dem_other && ((gmin_ok && !bus.det[act]) || gmax_ok)) begin
                    state_nx = S_YELLOW;
                end
            end
            S_YELLOW: begin
                if (tick && cnt_p1 >= YEL_C) begin
                    state_nx = S_ALLRED;
                end
            end
            S_ALLRED: begin
                if (tick && cnt_p1 >= ALLRED_C) begin
                    state_nx = S_GREEN;
                end
            end
            default: state_nx = S_ALLRED;
        endcase
    end

    always_comb begin
        red_nx = '1;
        yel_nx = '0;
        grn_nx = '0;
        if (state == S_GREEN) begin
            grn_nx = act_oh;
            red_nx = ~act_oh;
        end else if (state == S_YELLOW) begin
            yel_nx = act_oh;
            red_nx = ~act_oh;
        end
    end

    // Requests latch until their phase enters green; the clear dominates a same-cycle set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            act <= '0;
            req <= '0;
        end else begin
            req <= (req | bus.det) & ~clr;
            if (leave) begin
                cnt <= '0;
            end else if (tick && !(state == S_GREEN && cnt >= CSAT_C)) begin
                cnt <= cnt + 1'b1;
            end
            if (enter_grn) begin
                act <= nxt_ph;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.red    <= '1;
            bus.yel    <= '0;
            bus.grn    <= '0;
            bus.active <= '0;
            bus.st     <= S_ALLRED;
        end else begin
            bus.red    <= red_nx;
            bus.yel    <= yel_nx;
            bus.grn    <= grn_nx;
            bus.active <= act;
            bus.st     <= state;
        end
    end

endmodule

// File: doc/tlc_multi_phase.md
TLC_MULTI_PHASE -- requirements
Module: tlc_multi_phase

Interface
REQ-001 The block SHALL expose the following parameters, one per line as name, default, meaning:
- N_PHASES, 3, number of signal phases (2..4).
- PRESCALE, 4, clock cycles per timing tick (>=1).
- CNT_W, 8, tick-counter width; every duration SHALL be in the range 1..2^CNT_W-1.
- GREEN_MIN, 5, minimum green duration in ticks.
- GREEN_MAX, 12, maximum green duration in ticks (>=GREEN_MIN).
- YEL_T, 3, yellow duration in ticks.
- ALLRED_T, 2, all-red clearance duration in ticks.
- WALK_T, 4, walk duration in ticks (used only with TLC_PED_EN).

REQ-002 The block SHALL expose the following ports, one per line as name, direction, width, meaning:
- clk, in, 1, the single clock.
- rst_n, in, 1, reset, asynchronous and active-low.
- ena, in, 1, tick enable; when low, the prescaler and all timers freeze.
- det, in, N_PHASES, per-phase vehicle detector, level-sensitive.
- red, out, N_PHASES, per-phase red lamp.
- yel, out, N_PHASES, per-phase yellow lamp.
- grn, out, N_PHASES, per-phase green lamp.
- active, out, 2, index of the current or last-served phase.
- st, out, 2, FSM state code.
- ped_req, in, N_PHASES, pedestrian button (only with TLC_PED_EN).
- walk, out, N_PHASES, walk lamp (only with TLC_PED_EN).

Function
REQ-003 The tick generator SHALL pulse tick for 1 cycle every PRESCALE cycles while ena=1, and SHALL restart at 0 on every FSM state entry.
- Consequence: each state lasts exactly duration*PRESCALE enabled cycles.
REQ-004 The FSM SHALL have the states GREEN(00), YELLOW(01) and ALLRED(10).
- Code 11 is unused and SHALL recover to ALLRED.
REQ-005 The request latch req[i] SHALL be set on any cycle where det[i]=1, and cleared on the cycle phase i enters GREEN.
- When set and clear occur in the same cycle, clear SHALL win.
REQ-006 In GREEN, the counter g SHALL increment on each tick and saturate at GREEN_MAX.
- The FSM SHALL exit to YELLOW at a tick where another phase has a latched request and either (g+1>=GREEN_MIN and det[active]=0) or g+1>=GREEN_MAX.
REQ-007 With no other request latched, GREEN SHALL rest indefinitely regardless of GREEN_MAX.
REQ-008 YELLOW SHALL last YEL_T ticks; ALLRED SHALL last ALLRED_T ticks.
REQ-009 At ALLRED exit, the next phase SHALL be the first i with req[i]=1, searching cyclically from active+1.
- If no request is latched, the next phase SHALL be active.
- Phases without a request SHALL be skipped.
REQ-010 The lamps SHALL follow these rules:
- grn[active]=1 only in GREEN.
- yel[active]=1 only in YELLOW.
- All other lamps SHALL be red.
- Exactly one of red/yel/grn SHALL be high per phase on every cycle.
- At most one grn bit SHALL be high on any cycle.
REQ-011 All outputs SHALL be registered, and lamps SHALL change on the cycle after the state change.

Reset
REQ-012 On rst_n=0, the block SHALL immediately enter the following reset state, including mid-state:
- st=ALLRED, active=0, red=all ones, yel=0, grn=0, req=0, prescaler=0, timers=0, walk=0.
REQ-013 After rst_n release, the block SHALL complete ALLRED_T ticks and then enter GREEN on phase 0.

Configuration
REQ-014 With TLC_PED_EN defined, the block SHALL add ped_req, walk and a per-phase ped latch with the same set/clear rules as req.
- A latched ped request SHALL count as demand.
- On green entry with ped latched, walk[active]=1 for WALK_T ticks.
- In that case, the effective minimum green SHALL be max(GREEN_MIN, WALK_T+1).
REQ-015 Without TLC_PED_EN, the ped_req and walk ports and all ped logic SHALL be absent, and behaviour SHALL be exactly REQ-003..013.

Structure
REQ-016 The shared package tlc_pkg SHALL hold the state encoding constants and the phase index width.
REQ-017 The prescaler SHALL be the sub-module tlc_tick_gen (ports: clk, rst_n, ena, restart, tick).

Verification
All scenarios use the default parameters.
REQ-018 Reset release: the bench SHALL check 8 cycles all-red, then grn=001 on cycle 9.
REQ-019 No demand: the bench SHALL check that phase 0 stays green for 400 cycles.
REQ-020 det[2] pulse at green tick 1, det[1]=0: the bench SHALL check green held 20 cycles, yel[0] for 12 cycles, all-red for 8 cycles, then grn=100 (phase 1 skipped).
REQ-021 det[0] held high plus det[1] pulse: the bench SHALL check green lasts 48 cycles (GREEN_MAX), then phase 1 is served.
REQ-022 ena=0 for 10 cycles mid-YELLOW: the bench SHALL check that YELLOW is extended by exactly 10 cycles.
REQ-023 rst_n asserted mid-YELLOW: the bench SHALL check all-red and req=0 on the same cycle.
REQ-024 With TLC_PED_EN and WALK_T=6: the bench SHALL pulse ped_req[1] and check walk[1] high 24 cycles and green of at least 28 cycles.
